// File: rtl/cpu15_pc_unit.sv
// ---------------------------------------------------------------------------
// cpu15_pc_unit
//   Program-counter stage of the CPU15 core. Holds the instruction address
//   and sequences increment / jump / conditional jump / halt under a small
//   INIT -> RUN -> HALT state machine. Every output comes from a register,
//   so no input reaches an output within the same cycle.
//
// Ports
//   clk       in   1       system clock, rising-edge active
//   rst       in   1       asynchronous active-high reset
//   en        in   1       step enable (only meaningful in RUN)
//   op_jmp    in   1       unconditional jump request
//   op_jnz    in   1       jump-if-nonzero request
//   op_hlt    in   1       halt request (highest priority)
//   reg_nz    in   1       condition for op_jnz
//   target    in   ADDR_W  jump destination
//   restart   in   1       leave HALT and resume at RESET_ADDR
//   pc        out  ADDR_W  current instruction address
//   pc_valid  out  1       pc addresses an instruction to execute (RUN)
//   halted    out  1       FSM is in HALT
//   wrap      out  1       one-cycle pulse after an all-ones -> 0 increment
// ---------------------------------------------------------------------------
module cpu15_pc_unit #(
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              op_jmp,
  input  logic              op_jnz,
  input  logic              op_hlt,
  input  logic              reg_nz,
  input  logic [ADDR_W-1:0] target,
  input  logic              restart,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              halted,
  output logic              wrap
);

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_wrap;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_wrap_nxt;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + PC_ONE;

  // NOTE: combinational next-state logic uses blocking assignments and gives
  // every output a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      // Leave INIT on the first edge after reset release, independent of en.
      ST_INIT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (en) begin
          if (op_hlt) begin
            // pc keeps pointing at the HLT instruction.
            w_state_nxt = ST_HALT;
          end else if (op_jmp || (op_jnz && reg_nz)) begin
            // A jump landing on 0 is not a wrap.
            w_pc_nxt = target;
          end else begin
            w_pc_nxt   = w_pc_inc;
            w_wrap_nxt = &r_pc;
          end
        end
      end
      ST_HALT: begin
        if (restart) begin
          w_pc_nxt    = RESET_ADDR;
          w_state_nxt = ST_RUN;
        end
      end
      // Unused encoding: recover through INIT.
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_pc    <= RESET_ADDR;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Pure decodes of registered state: still no input-to-output path.
  assign pc       = r_pc;
  assign pc_valid = (r_state == ST_RUN);
  assign halted   = (r_state == ST_HALT);
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_cpu15_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu15_pc_unit
//   Directed self-checking bench for cpu15_pc_unit (ADDR_W=8, RESET_ADDR=0).
//   Observed outputs are packed as {pc, pc_valid, halted, wrap} and sampled
//   on the falling clock edge; inputs are also changed on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu15_pc_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic       op_jmp;
  logic       op_jnz;
  logic       op_hlt;
  logic       reg_nz;
  logic [7:0] target;
  logic       restart;
  logic [7:0] pc;
  logic       pc_valid;
  logic       halted;
  logic       wrap;

  logic [10:0] obs;
  int          n_checks;
  int          n_errors;

  assign obs = {pc, pc_valid, halted, wrap};

  cpu15_pc_unit #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .op_jmp   (op_jmp),
    .op_jnz   (op_jnz),
    .op_hlt   (op_hlt),
    .reg_nz   (reg_nz),
    .target   (target),
    .restart  (restart),
    .pc       (pc),
    .pc_valid (pc_valid),
    .halted   (halted),
    .wrap     (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clear all op requests; en left as is.
  task automatic no_ops();
    op_jmp  = 1'b0;
    op_jnz  = 1'b0;
    op_hlt  = 1'b0;
    reg_nz  = 1'b0;
    restart = 1'b0;
    target  = 8'h00;
  endtask

  // One rising edge, then return at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [7:0] addr);
    no_ops();
    en     = 1'b1;
    op_jmp = 1'b1;
    target = addr;
    step();
    no_ops();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    no_ops();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== {8'h00, 3'b000}) begin
      n_errors++; $display("FAIL reset_values: got %h want %h", obs, {8'h00, 3'b000});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== {8'h00, 3'b000}) begin
      n_errors++; $display("FAIL init_state: got %h want %h", obs, {8'h00, 3'b000});
    end
    step();
    n_checks++;
    if (obs !== {8'h00, 3'b100}) begin
      n_errors++; $display("FAIL run_pc0: got %h want %h", obs, {8'h00, 3'b100});
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (obs !== {8'(i), 3'b100}) begin
        n_errors++; $display("FAIL run_inc%0d: got %h want %h", i, obs, {8'(i), 3'b100});
      end
    end
  endtask

  task automatic test_jump();
    jump_to(8'h10);
    n_checks++;
    if (obs !== {8'h10, 3'b100}) begin
      n_errors++; $display("FAIL jmp_0x10: got %h want %h", obs, {8'h10, 3'b100});
    end
    jump_to(8'h80);
    n_checks++;
    if (obs !== {8'h80, 3'b100}) begin
      n_errors++; $display("FAIL jmp_0x80: got %h want %h", obs, {8'h80, 3'b100});
    end
    op_jnz = 1'b1; reg_nz = 1'b0; target = 8'h33;
    step();
    no_ops();
    n_checks++;
    if (obs !== {8'h81, 3'b100}) begin
      n_errors++; $display("FAIL jnz_not_taken: got %h want %h", obs, {8'h81, 3'b100});
    end
    op_jnz = 1'b1; reg_nz = 1'b1; target = 8'h05;
    step();
    no_ops();
    n_checks++;
    if (obs !== {8'h05, 3'b100}) begin
      n_errors++; $display("FAIL jnz_taken: got %h want %h", obs, {8'h05, 3'b100});
    end
  endtask

  task automatic test_wrap();
    jump_to(8'hFE);
    step();
    n_checks++;
    if (obs !== {8'hFF, 3'b100}) begin
      n_errors++; $display("FAIL inc_to_ff: got %h want %h", obs, {8'hFF, 3'b100});
    end
    step();
    n_checks++;
    if (obs !== {8'h00, 3'b101}) begin
      n_errors++; $display("FAIL wrap_pulse: got %h want %h", obs, {8'h00, 3'b101});
    end
    step();
    n_checks++;
    if (obs !== {8'h01, 3'b100}) begin
      n_errors++; $display("FAIL wrap_one_cycle: got %h want %h", obs, {8'h01, 3'b100});
    end
    // At all-ones with en=0: no increment, no wrap.
    jump_to(8'hFF);
    en = 1'b0;
    step();
    n_checks++;
    if (obs !== {8'hFF, 3'b100}) begin
      n_errors++; $display("FAIL ff_en0_no_wrap: got %h want %h", obs, {8'hFF, 3'b100});
    end
    // Jump from all-ones to 0 is not a wrap.
    jump_to(8'h00);
    n_checks++;
    if (obs !== {8'h00, 3'b100}) begin
      n_errors++; $display("FAIL jmp_to_0_no_wrap: got %h want %h", obs, {8'h00, 3'b100});
    end
  endtask

  task automatic test_halt();
    jump_to(8'h22);
    op_hlt = 1'b1; op_jmp = 1'b1; target = 8'h99;
    step();
    n_checks++;
    if (obs !== {8'h22, 3'b010}) begin
      n_errors++; $display("FAIL hlt_over_jmp: got %h want %h", obs, {8'h22, 3'b010});
    end
    op_hlt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = i[0];
      step();
      n_checks++;
      if (obs !== {8'h22, 3'b010}) begin
        n_errors++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, {8'h22, 3'b010});
      end
    end
    no_ops();
    en      = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    en      = 1'b1;
    n_checks++;
    if (obs !== {8'h00, 3'b100}) begin
      n_errors++; $display("FAIL restart: got %h want %h", obs, {8'h00, 3'b100});
    end
    // restart while already running has no effect.
    restart = 1'b1;
    step();
    step();
    restart = 1'b0;
    n_checks++;
    if (obs !== {8'h02, 3'b100}) begin
      n_errors++; $display("FAIL restart_in_run: got %h want %h", obs, {8'h02, 3'b100});
    end
  endtask

  task automatic test_enable();
    logic [7:0] exp_pc [4];
    logic       en_seq [4];
    exp_pc = '{8'h04, 8'h04, 8'h04, 8'h05};
    en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    jump_to(8'h03);
    for (int i = 0; i < 4; i++) begin
      no_ops();
      en = en_seq[i];
      // A jump offered while disabled must be dropped.
      if (i == 2) begin
        op_jmp = 1'b1;
        target = 8'hAA;
      end
      step();
      n_checks++;
      if (obs !== {exp_pc[i], 3'b100}) begin
        n_errors++; $display("FAIL en_seq%0d: got %h want %h", i, obs, {exp_pc[i], 3'b100});
      end
    end
    no_ops();
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    op_jmp = 1'b1; target = 8'h30;
    step();
    op_jmp = 1'b0; op_jnz = 1'b1; reg_nz = 1'b1; target = 8'h70;
    step();
    no_ops();
    n_checks++;
    if (obs !== {8'h70, 3'b100}) begin
      n_errors++; $display("FAIL b2b_jumps: got %h want %h", obs, {8'h70, 3'b100});
    end
  endtask

  task automatic test_async_reset();
    jump_to(8'h40);
    n_checks++;
    if (obs !== {8'h40, 3'b100}) begin
      n_errors++; $display("FAIL pre_reset_pc: got %h want %h", obs, {8'h40, 3'b100});
    end
    // Assert reset between edges; outputs must change before the next rise.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== {8'h00, 3'b000}) begin
      n_errors++; $display("FAIL async_reset: got %h want %h", obs, {8'h00, 3'b000});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if (obs !== {8'h00, 3'b100}) begin
      n_errors++; $display("FAIL post_reset_init: got %h want %h", obs, {8'h00, 3'b100});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_jump();
    test_wrap();
    test_halt();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
